// File: rtl/param_register_file_pkg.sv
// param_register_file_pkg: default geometry and clear-FSM state type shared by the register file
package regfile_pkg;
    localparam int DEF_DATA_W = 24;
    localparam int DEF_DEPTH = 16;
    typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/param_register_file_if.sv
// param_register_file_if: decode/writeback bus of the register file
//   master (decode/writeback side): drives RS, RT, RD, WriteData, RegWrite; sees ReadRS, ReadRT, Ready
//   slave  (register file):         the mirror image
interface param_register_file_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = $clog2(DEF_DEPTH)
);
    logic [ADDR_W-1:0] RS;
    logic [ADDR_W-1:0] RT;
    logic [ADDR_W-1:0] RD;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [DATA_W-1:0] ReadRS;
    logic [DATA_W-1:0] ReadRT;
    logic              Ready;
    modport master (output RS, RT, RD, WriteData, RegWrite, input ReadRS, ReadRT, Ready);
    modport slave  (input RS, RT, RD, WriteData, RegWrite, output ReadRS, ReadRT, Ready);
endinterface

// File: rtl/param_register_file_clear_ctrl.sv
// regfile_clear_ctrl: post-reset sweep that zeroes one entry per cycle, then reports Ready
//   Clock, Reset (sync, active-high) in; Ready, clr_en, clr_addr out
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic              Ready,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Reset has priority, so no entry is cleared while it is held
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_en    = state == CLEAR && !Reset;
        if (clr_en) begin
            ptr_nxt   = ptr + ADDR_W'(1);
            state_nxt = 32'(ptr) == DEPTH - 1 ? READY : CLEAR;
        end
    end

    assign Ready    = state == READY;
    assign clr_addr = ptr;
endmodule

// File: rtl/param_register_file.sv
// param_register_file: 2R/1W register file with clear sweep, optional zero register and bypass
//   Clock, Reset (sync, active-high) plain ports; bus (slave modport) carries addresses, data, Ready
//   Define REGFILE_BYPASS_EN to forward WriteData to a matching read port in the same cycle
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    param_register_file_if.slave  bus
);
    logic [DATA_W-1:0] regs [DEPTH];
    logic              ready, clr_en, wr_ok, we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] rs_val, rt_val;

    // address is backed by a real, writable entry
    function automatic logic live(logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH && !(ZERO_REG != 0 && a == '0);
    endfunction

    regfile_clear_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
        .Clock    (Clock),
        .Reset    (Reset),
        .Ready    (ready),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // wr_ok also qualifies the bypass, which does not look at Reset
    assign wr_ok = ready && bus.RegWrite && live(bus.RD);
    assign we    = wr_ok && !Reset;

    always_ff @(posedge Clock) begin
        if (clr_en)
            regs[clr_addr] <= '0;
        else if (we)
            regs[bus.RD] <= bus.WriteData;
    end

    assign rs_val = ready && live(bus.RS) ? regs[bus.RS] : '0;
    assign rt_val = ready && live(bus.RT) ? regs[bus.RT] : '0;

`ifdef REGFILE_BYPASS_EN
    assign bus.ReadRS = wr_ok && bus.RD == bus.RS ? bus.WriteData : rs_val;
    assign bus.ReadRT = wr_ok && bus.RD == bus.RT ? bus.WriteData : rt_val;
`else
    assign bus.ReadRS = rs_val;
    assign bus.ReadRT = rt_val;
`endif

    assign bus.Ready = ready;
endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: default instance plus a DEPTH=12/ZERO_REG=1 instance against an array model
module tb_param_register_file;
    logic        Clock;
    logic        Reset;
    logic [3:0]  rs [2];
    logic [3:0]  rt [2];
    logic [3:0]  rd [2];
    logic [23:0] wd [2];
    logic        we [2];
    int          total = 0;
    int          bad = 0;

    logic [23:0] mem [2][16];
    int          cnt [2];
    bit          rdy [2];

    param_register_file_if #(.DATA_W(24), .ADDR_W(4)) b0 ();
    param_register_file_if #(.DATA_W(24), .ADDR_W(4)) b1 ();

    param_register_file u0 (.Clock(Clock), .Reset(Reset), .bus(b0));
    param_register_file #(.DEPTH(12), .ZERO_REG(1)) u1 (.Clock(Clock), .Reset(Reset), .bus(b1));

    assign b0.RS = rs[0];
    assign b0.RT = rt[0];
    assign b0.RD = rd[0];
    assign b0.WriteData = wd[0];
    assign b0.RegWrite = we[0];
    assign b1.RS = rs[1];
    assign b1.RT = rt[1];
    assign b1.RD = rd[1];
    assign b1.WriteData = wd[1];
    assign b1.RegWrite = we[1];

    initial Clock = 0;
    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit live(int k, logic [3:0] a);
        return int'(a) < (k == 1 ? 12 : 16) && !(k == 1 && a == 4'd0);
    endfunction

    function automatic logic [23:0] exp_rd(int k, logic [3:0] a);
        logic [23:0] r;
        r = rdy[k] && live(k, a) ? mem[k][a] : 24'd0;
`ifdef REGFILE_BYPASS_EN
        if (rdy[k] && we[k] && live(k, rd[k]) && rd[k] == a) r = wd[k];
`endif
        return r;
    endfunction

    // what one rising edge does, in the terms of the behaviour rules
    task automatic upd(int k);
        if (Reset) begin
            cnt[k] = 0;
            rdy[k] = 0;
        end else if (!rdy[k]) begin
            mem[k][cnt[k]] = 24'd0;
            cnt[k]++;
            if (cnt[k] == (k == 1 ? 12 : 16)) rdy[k] = 1;
        end else if (we[k] && live(k, rd[k])) begin
            mem[k][rd[k]] = wd[k];
        end
    endtask

    task automatic tick();
        upd(0);
        upd(1);
        @(posedge Clock);
        #1;
    endtask

    task automatic check_all();
        #1;
        check("rdy0", 32'(b0.Ready), 32'(rdy[0]));
        check("rs0", 32'(b0.ReadRS), 32'(exp_rd(0, rs[0])));
        check("rt0", 32'(b0.ReadRT), 32'(exp_rd(0, rt[0])));
        check("rdy1", 32'(b1.Ready), 32'(rdy[1]));
        check("rs1", 32'(b1.ReadRS), 32'(exp_rd(1, rs[1])));
        check("rt1", 32'(b1.ReadRT), 32'(exp_rd(1, rt[1])));
    endtask

    task automatic sweep();
        for (int i = 1; i <= 16; i++) begin
            for (int k = 0; k < 2; k++) begin
                rs[k] = 4'($urandom);
                rt[k] = 4'($urandom);
            end
            tick();
            check("sweep_rdy0", 32'(b0.Ready), 32'(i >= 16));
            check("sweep_rdy1", 32'(b1.Ready), 32'(i >= 12));
            check_all();
        end
    endtask

    initial begin
        int n;
        Reset = 1;
        for (int k = 0; k < 2; k++) begin
            rs[k] = 0; rt[k] = 0; rd[k] = 0; wd[k] = 0; we[k] = 0;
            cnt[k] = 0; rdy[k] = 0;
        end
        tick();
        tick();
        check_all();
        check("reset_ready", 32'(b0.Ready), 32'd0);
        Reset = 0;
        sweep();

        // preload every entry, then sweep again and expect all zeros
        for (int a = 0; a < 16; a++) begin
            for (int k = 0; k < 2; k++) begin
                rd[k] = 4'(a); wd[k] = 24'hABCDEF; we[k] = 1;
                rs[k] = 4'(a); rt[k] = 4'($urandom);
            end
            check_all();
            tick();
            check_all();
        end
        we[0] = 0;
        we[1] = 0;
        rs[0] = 4'd9;
        check_all();
        check("preload", 32'(b0.ReadRS), 32'hABCDEF);
        Reset = 1;
        tick();
        Reset = 0;
        check_all();
        sweep();
        for (int a = 0; a < 16; a++) begin
            rs[0] = 4'(a); rt[0] = 4'(15 - a);
            rs[1] = 4'(a); rt[1] = 4'(15 - a);
            check_all();
            check("cleared", 32'(b0.ReadRS), 32'd0);
        end

        // basic write/read
        rd[0] = 4'd5; wd[0] = 24'h123456; we[0] = 1;
        tick();
        rd[0] = 4'd15; wd[0] = 24'hFFFFFF;
        tick();
        we[0] = 0; rs[0] = 4'd5; rt[0] = 4'd15;
        check_all();
        check("basic_rs", 32'(b0.ReadRS), 32'h123456);
        check("basic_rt", 32'(b0.ReadRT), 32'hFFFFFF);

        // reset again at sweep cycle 7 with a write to reg 3 pending
        Reset = 1;
        tick();
        Reset = 0;
        rd[0] = 4'd3; wd[0] = 24'h333333; we[0] = 1; rs[0] = 4'd3;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_all();
        end
        Reset = 1;
        tick();
        Reset = 0;
        n = 0;
        while (!b0.Ready && n < 40) begin
            tick();
            n++;
            check_all();
        end
        check("midsweep_latency", 32'(n), 32'd16);
        we[0] = 0;
        check_all();
        check("reg3_zero", 32'(b0.ReadRS), 32'd0);

        // zero register and out-of-range on the DEPTH=12 instance
        rd[1] = 4'd0; wd[1] = 24'h777777; we[1] = 1;
        tick();
        rd[1] = 4'd13;
        tick();
        rd[1] = 4'd11; wd[1] = 24'hBEEF11;
        tick();
        we[1] = 0; rs[1] = 4'd0; rt[1] = 4'd13;
        check_all();
        check("zero_reg", 32'(b1.ReadRS), 32'd0);
        check("out_of_range", 32'(b1.ReadRT), 32'd0);
        rs[1] = 4'd11;
        check_all();
        check("reg11", 32'(b1.ReadRS), 32'hBEEF11);

        // same-cycle read of the address being written
        rd[0] = 4'd4; wd[0] = 24'h000001; we[0] = 1;
        tick();
        wd[0] = 24'h00AA55; rs[0] = 4'd4; rt[0] = 4'd4;
        check_all();
`ifdef REGFILE_BYPASS_EN
        check("bypass_rs", 32'(b0.ReadRS), 32'h00AA55);
        check("bypass_rt", 32'(b0.ReadRT), 32'h00AA55);
`else
        check("old_rs", 32'(b0.ReadRS), 32'h000001);
        check("old_rt", 32'(b0.ReadRT), 32'h000001);
`endif
        tick();
        we[0] = 0;
        check_all();
        check("after_edge", 32'(b0.ReadRS), 32'h00AA55);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            Reset = $urandom_range(0, 39) == 0;
            for (int k = 0; k < 2; k++) begin
                rs[k] = 4'($urandom);
                rt[k] = 4'($urandom);
                rd[k] = 4'($urandom);
                wd[k] = 24'($urandom);
                we[k] = $urandom_range(0, 1) == 1;
            end
            check_all();
            tick();
            check_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised successor to the CPU's 24-bit, 16-entry register file. It keeps two asynchronous read ports and one clocked write port, and adds:
- a synchronous-reset clear sweep that zeroes the array one entry per cycle, with a `Ready` status output;
- an optional hardwired zero register;
- out-of-range address protection;
- an optional write-to-read bypass.

It sits between decode (register addresses) and the ALU/writeback path of the datapath.

## Interface
- `DATA_W`, default 24, register width in bits.
- `DEPTH`, default 16, number of registers (2..256, need not be a power of two).
- `ADDR_W`, default $clog2(DEPTH), address width.
- `ZERO_REG`, default 0; 1 = register 0 always reads 0 and writes to it are discarded.
- `Clock` input 1: single clock, rising edge. One clock; reset is synchronous and active-high.
- `Reset` input 1: synchronous, active-high; starts the clear sweep.
- `RS` input ADDR_W: read address, port S.
- `RT` input ADDR_W: read address, port T.
- `RD` input ADDR_W: write address.
- `WriteData` input DATA_W: write data.
- `RegWrite` input 1: write enable.
- `ReadRS` output DATA_W: contents at `RS`.
- `ReadRT` output DATA_W: contents at `RT`.
- `Ready` output 1: high once the array is cleared and accepting writes.

## Operation
- FSM states: CLEAR and READY.
  - An edge with `Reset`=1 sets state to CLEAR and the pointer to 0, from any state, including mid-sweep (the sweep restarts from entry 0).
  - Each CLEAR edge with `Reset`=0 writes 0 to `Registers[ptr]` and increments ptr.
  - The edge that writes `ptr`==DEPTH-1 moves the state to READY.
  - READY is held until the next `Reset`.
  - While `Reset` is held high, ptr stays at 0 and no entry is cleared.
- `Ready` is 1 exactly when the state is READY.
- Writes: at an edge with state READY, `RegWrite`=1 and `RD`<DEPTH, `Registers[RD]` is set to `WriteData`. The write is discarded in any of these cases:
  - state is CLEAR;
  - `Reset`=1 on that edge;
  - `RD`>=DEPTH;
  - `ZERO_REG`=1 and `RD`=0.
- Reads are combinational. `ReadRS`/`ReadRT` return 0 in any of these cases:
  - state is CLEAR;
  - the address is >=DEPTH;
  - `ZERO_REG`=1 and the address is 0.
  
  Otherwise they return the stored entry.
- `RS`==`RT` is legal; both ports return the same value.
- Array contents before the first `Reset` are undefined. Integration asserts `Reset` after power-up.

## Timing
- Reset values:
  - `Ready`=0;
  - `ReadRS`=0 and `ReadRT`=0 for the whole sweep;
  - state CLEAR, ptr 0.
- Clear latency: `Ready` rises on the DEPTH-th rising edge after the first edge with `Reset`=0. This is 16 cycles at the default.
- Write latency: data written at edge N is visible on the read ports immediately after edge N.
- Read-during-write to the same address, same cycle, without bypass: the read returns the old value until the edge.
- A write presented in the same cycle that `Ready` is still 0 is lost. Writers gate on `Ready`.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: write-to-read bypass is active. When all of the following hold, the matching read port returns `WriteData` combinationally in the same cycle:
  - state is READY;
  - `RegWrite`=1;
  - `RD`<DEPTH;
  - not (`ZERO_REG`=1 and `RD`=0);
  - `RD` equals `RS` and/or `RT`.
- Not defined: no bypass; reads always return array contents as described under Timing.

## Structure
- Package `regfile_pkg`:
  - default `DATA_W` (24) and `DEPTH` (16) constants;
  - state enum `{CLEAR, READY}`.
- Sub-module `regfile_clear_ctrl`:
  - contents: FSM plus ptr counter;
  - outputs: `Ready`, `clr_en` and `clr_addr`.
- The top level holds the array, the write/clear mux, the read masking and the bypass logic.

## Test plan
- **Reset sweep:** preload 0xABCDEF in every register, assert `Reset` 1 cycle, then release.
  - `Ready`=0 for 16 edges, then 1.
  - All reads return 0.
  - Every register reads 0 after `Ready`.
- **Basic write/read:** write 0x123456 to reg 5 and 0xFFFFFF to reg 15, with `RS`=5 and `RT`=15.
  - `ReadRS`=0x123456 and `ReadRT`=0xFFFFFF after the write edges.
- **Mid-sweep reset:** assert `Reset` again at sweep cycle 7.
  - `Ready` rises exactly 16 edges after the second release.
  - A `RegWrite` to reg 3 during the sweep leaves reg 3 reading 0.
- **Zero register and range:** `ZERO_REG`=1, `DEPTH`=12; write 0x777777 to reg 0 and to reg 13.
  - Reading reg 0 and reg 13 returns 0.
  - Reg 11 write/read still works.
- **Bypass:** with `REGFILE_BYPASS_EN`, `RD`=`RS`=`RT`=4, `WriteData`=0x00AA55, reg 4 holding 0x000001.
  - Both ports show 0x00AA55 in the same cycle.
  - Without the macro they show 0x000001 until the edge, then 0x00AA55.
